// File: rtl/comb_bist_ctrl.sv
// comb_bist_ctrl: LFSR-driven BIST wrapper for one combinational core.
// Ports: clk, rst (async high), start, abort, golden_sig in;
//   dut_in to core, dut_out from core; busy, done, pass,
//   signature (MISR), pat_count (vectors applied) out.
module comb_bist_ctrl #(
  parameter int IN_W = 10,
  parameter int OUT_W = 12,
  parameter int PAT_CNT = 1023,
  parameter logic [IN_W-1:0] LFSR_TAPS = 10'h240,
  parameter logic [IN_W-1:0] LFSR_SEED = 10'h001,
  parameter logic [OUT_W-1:0] MISR_TAPS = 12'hE08
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] golden_sig,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [IN_W:0]    pat_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [IN_W:0] PAT_LAST = (IN_W+1)'(PAT_CNT);

  state_t state;
  logic [OUT_W-1:0] resp_q;
  // resp_q holds a real response only after the first RUN cycle
  logic absorb;

  function automatic logic [IN_W-1:0] lfsr_next(
    input logic [IN_W-1:0] q
  );
    return {q[IN_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [OUT_W-1:0] misr_next(
    input logic [OUT_W-1:0] s,
    input logic [OUT_W-1:0] r
  );
    return {s[OUT_W-2:0], ^(s & MISR_TAPS)} ^ r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      pat_count <= '0;
      resp_q    <= '0;
      absorb    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // freeze signature/pat_count; a finished pass stays visible
        state <= IDLE;
        busy  <= 1'b0;
        if (state != IDLE) pass <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state     <= RUN;
              busy      <= 1'b1;
              dut_in    <= LFSR_SEED;
              signature <= '0;
              pat_count <= {{IN_W{1'b0}}, 1'b1};
              pass      <= 1'b0;
              absorb    <= 1'b0;
            end
          end
          RUN: begin
            resp_q <= dut_out;
            absorb <= 1'b1;
            if (absorb)
              signature <= misr_next(signature, resp_q);
            if (pat_count == PAT_LAST) begin
              state <= DRAIN;
            end else begin
              dut_in    <= lfsr_next(dut_in);
              pat_count <= pat_count + 1'b1;
            end
          end
          DRAIN: begin
            signature <= misr_next(signature, resp_q);
            state     <= DONE;
            busy      <= 1'b0;
          end
          DONE: begin
            // verdict and done land together so pass is valid with done
            done  <= 1'b1;
            pass  <= (signature == golden_sig);
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
